// File: rtl/riscv_imm_pkg.sv
// Shared RISC-V immediate definitions, used by both the immediate extender and
// the immediate inserter.
//  - imm_src_e      : format select code (same encoding as the extender's ImmSrc)
//  - MSB_*          : highest significant immediate bit per format
//  - imm_msb        : format -> MSB lookup
//  - imm_fits       : signed range check (all bits from MSB upward are sign copies)
//  - imm_misaligned : B/J immediates must be even
package riscv_imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam int unsigned MSB_I = 11;
    localparam int unsigned MSB_S = 11;
    localparam int unsigned MSB_B = 12;
    localparam int unsigned MSB_J = 20;

    function automatic int unsigned imm_msb(input logic [1:0] src);
        case (src)
            IMM_I:   return MSB_I;
            IMM_S:   return MSB_S;
            IMM_B:   return MSB_B;
            default: return MSB_J;
        endcase
    endfunction

    // Arithmetic shift leaves only the sign-redundant bits; they must be all 0 or all 1.
    function automatic logic imm_fits(input logic [31:0] imm, input logic [1:0] src);
        logic [31:0] upper;
        upper = $signed(imm) >>> imm_msb(src);
        return (upper == '0) || (upper == '1);
    endfunction

    function automatic logic imm_misaligned(input logic [31:0] imm, input logic [1:0] src);
        return imm[0] && ((src == IMM_B) || (src == IMM_J));
    endfunction

endpackage

// File: rtl/imm_inserter_if.sv
// Stream interface of the immediate inserter.
//  in_*  : input beat (base instruction, signed immediate, format) with valid/ready
//  out_* : packed instruction plus range/alignment flags with valid/ready
//  master : producer of input beats / consumer of output beats
//  slave  : the inserter itself
interface imm_inserter_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [1:0]  in_src;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_range;
    logic        out_align;

    modport master (
        output in_valid, in_base, in_imm, in_src, out_ready,
        input  in_ready, out_valid, out_instr, out_range, out_align
    );

    modport slave (
        input  in_valid, in_base, in_imm, in_src, out_ready,
        output in_ready, out_valid, out_instr, out_range, out_align
    );

endinterface

// File: rtl/imm_pack.sv
// Combinational immediate packer: drops the immediate bits of imm_i into the
// I/S/B/J field positions of base_i; all other bits of base_i pass unchanged.
//  base_i  : base instruction word
//  imm_i   : signed immediate (only the bits the format encodes are used)
//  src_i   : format select (imm_src_e encoding)
//  instr_o : packed instruction
module imm_pack
    import riscv_imm_pkg::*;
(
    input  logic [31:0] base_i,
    input  logic [31:0] imm_i,
    input  logic [1:0]  src_i,
    output logic [31:0] instr_o
);

    always_comb begin
        instr_o = base_i;
        case (src_i)
            IMM_I: instr_o = {imm_i[11:0], base_i[19:0]};
            IMM_S: instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
            IMM_B: instr_o = {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1], imm_i[11],
                              base_i[6:0]};
            IMM_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
            default: instr_o = base_i;
        endcase
    end

    // Upper immediate bits only feed the range check upstream, never the encoding.
    logic unused_imm;
    assign unused_imm = ^imm_i[31:21];

endmodule

// File: rtl/imm_inserter.sv
// Immediate inserter: packs a signed immediate into a RISC-V base instruction,
// flags out-of-range / misaligned immediates and counts flagged deliveries.
// Two-stage valid/ready pipeline, full throughput, latency 2.
//  clk       : rising-edge clock
//  rst       : synchronous active-high reset, discards all in-flight beats
//  bus_io    : input and output streams (slave side)
//  err_count : saturating count of delivered beats with range or align set
module imm_inserter
    import riscv_imm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_inserter_if.slave    bus_io,
    output logic [CNT_W-1:0] err_count
);

    // Stage 1: captured input plus flags
    logic        s1_v_q,     s1_v_d;
    logic [31:0] s1_base_q,  s1_base_d;
    logic [31:0] s1_imm_q,   s1_imm_d;
    logic [1:0]  s1_src_q,   s1_src_d;
    logic        s1_range_q, s1_range_d;
    logic        s1_align_q, s1_align_d;

    // Stage 2: packed word driving the outputs
    logic        s2_v_q,     s2_v_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_range_q, s2_range_d;
    logic        s2_align_q, s2_align_d;

    logic [CNT_W-1:0] err_q, err_d;

    logic        s1_adv, s2_adv;
    logic [31:0] pack_instr;

    imm_pack u_pack (
        .base_i  (s1_base_q),
        .imm_i   (s1_imm_q),
        .src_i   (s1_src_q),
        .instr_o (pack_instr)
    );

    // A stage advances when it is empty or its successor advances; in_ready
    // therefore depends only on state and out_ready, never on in_valid.
    always_comb begin
        s2_adv = !s2_v_q || bus_io.out_ready;
        s1_adv = !s1_v_q || s2_adv;
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_base_d  = s1_base_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_range_d = s1_range_q;
        s1_align_d = s1_align_q;
        if (s1_adv) begin
            s1_v_d = bus_io.in_valid;
            if (bus_io.in_valid) begin
                s1_base_d  = bus_io.in_base;
                s1_imm_d   = bus_io.in_imm;
                s1_src_d   = bus_io.in_src;
                s1_range_d = !imm_fits(bus_io.in_imm, bus_io.in_src);
                s1_align_d = imm_misaligned(bus_io.in_imm, bus_io.in_src);
            end
        end
    end

    always_comb begin
        s2_v_d     = s2_v_q;
        s2_instr_d = s2_instr_q;
        s2_range_d = s2_range_q;
        s2_align_d = s2_align_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_instr_d = pack_instr;
                s2_range_d = s1_range_q;
                s2_align_d = s1_align_q;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (s2_v_q && bus_io.out_ready && (s2_range_q || s2_align_q) && (err_q != '1)) begin
            err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_base_q  <= '0;
            s1_imm_q   <= '0;
            s1_src_q   <= '0;
            s1_range_q <= 1'b0;
            s1_align_q <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_instr_q <= '0;
            s2_range_q <= 1'b0;
            s2_align_q <= 1'b0;
            err_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_base_q  <= s1_base_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_range_q <= s1_range_d;
            s1_align_q <= s1_align_d;
            s2_v_q     <= s2_v_d;
            s2_instr_q <= s2_instr_d;
            s2_range_q <= s2_range_d;
            s2_align_q <= s2_align_d;
            err_q      <= err_d;
        end
    end

    assign bus_io.in_ready  = s1_adv;
    assign bus_io.out_valid = s2_v_q;
    assign bus_io.out_instr = s2_instr_q;
    assign bus_io.out_range = s2_range_q;
    assign bus_io.out_align = s2_align_q;
    assign err_count        = err_q;

endmodule

// File: tb/tb_imm_inserter.sv
// Self-checking bench for imm_inserter: directed format cases, backpressure,
// randomized round trip through an independent extender, reset and saturation.
module tb_imm_inserter;
    import riscv_imm_pkg::*;

    localparam int unsigned CntW = 4;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [CntW-1:0] err_count;

    imm_inserter_if bus ();

    imm_inserter #(.CNT_W(CntW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_io    (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned ec_model = 0;

    // ---------------- reference model ----------------
    function automatic int model_msb(input logic [1:0] s);
        case (s)
            2'd0: return 11;
            2'd1: return 11;
            2'd2: return 12;
            default: return 20;
        endcase
    endfunction

    function automatic logic model_range(input logic [31:0] imm, input logic [1:0] s);
        longint v, lim;
        v   = longint'($signed(imm));
        lim = 64'sd1 <<< model_msb(s);
        return (v < -lim) || (v >= lim);
    endfunction

    function automatic logic model_align(input logic [31:0] imm, input logic [1:0] s);
        return (s >= 2'd2) && imm[0];
    endfunction

    function automatic logic [31:0] model_pack(input logic [31:0] b, input logic [31:0] imm,
                                               input logic [1:0] s);
        case (s)
            2'd0: return (b & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
            2'd1: return (b & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25)
                       | ((imm & 32'h1F) << 7);
            2'd2: return (b & 32'h01FF_F07F) | (((imm >> 12) & 32'd1) << 31)
                       | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 32'd1) << 7);
            default: return (b & 32'h0000_0FFF) | (((imm >> 20) & 32'd1) << 31)
                          | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'd1) << 20)
                          | (((imm >> 12) & 32'hFF) << 12);
        endcase
    endfunction

    // Standard RISC-V immediate extender, used for the round trip.
    function automatic logic [31:0] extend(input logic [31:0] x, input logic [1:0] s);
        case (s)
            2'd0: return {{20{x[31]}}, x[31:20]};
            2'd1: return {{20{x[31]}}, x[31:25], x[11:7]};
            2'd2: return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            default: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        endcase
    endfunction

    task automatic note_delivery(input logic flagged);
        if (flagged && ec_model < CntMax) ec_model++;
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic drive(input logic v, input logic [31:0] b, input logic [31:0] i,
                         input logic [1:0] s, input logic ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_base   = b;
        bus.in_imm    = i;
        bus.in_src    = s;
        bus.out_ready = ordy;
        #1;
    endtask

    // Offer one beat into an empty pipe and wait for it; lat counts cycles from accept.
    task automatic send_one(input logic [31:0] b, input logic [31:0] i, input logic [1:0] s,
                            output logic [31:0] instr, output logic rng, output logic aln,
                            output int lat, output logic ok);
        ok = 1'b0; lat = 0; instr = '0; rng = 1'b0; aln = 1'b0;
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, b, i, s, 1'b1);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) return;
        for (int n = 1; n <= 20; n++) begin
            drive(1'b0, b, i, s, 1'b1);
            if (bus.out_valid) begin
                instr = bus.out_instr; rng = bus.out_range; aln = bus.out_align;
                lat = n; ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++;
            $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
        n_checks++; if ({bus.out_range, bus.out_align} !== 2'b00) begin n_fail++;
            $display("FAIL reset_flags: got %b%b want 00", bus.out_range, bus.out_align); end
        n_checks++; if (err_count !== '0) begin n_fail++;
            $display("FAIL reset_err_count: got %0d want 0", err_count); end
        rst = 1'b0;
        ec_model = 0;
    endtask

    task automatic test_i_format();
        logic [31:0] instr; logic rng, aln, ok; int lat;
        send_one(32'h0000_0013, 32'hFFFF_FF23, IMM_I, instr, rng, aln, lat, ok);
        n_checks++; if (ok !== 1'b1 || lat != 2) begin n_fail++;
            $display("FAIL i_latency: got ok=%b lat=%0d want ok=1 lat=2", ok, lat); end
        n_checks++; if (instr !== 32'hF230_0013) begin n_fail++;
            $display("FAIL i_instr: got %h want f2300013", instr); end
        n_checks++; if ({rng, aln} !== 2'b00) begin n_fail++;
            $display("FAIL i_flags: got %b%b want 00", rng, aln); end
        note_delivery(1'b0);
    endtask

    task automatic test_s_format();
        logic [31:0] instr; logic rng, aln, ok; int lat;
        send_one(32'h0000_0023, 32'd5, IMM_S, instr, rng, aln, lat, ok);
        n_checks++; if (!ok || instr !== 32'h0000_02A3 || {rng, aln} !== 2'b00) begin n_fail++;
            $display("FAIL s_instr: got %h flags %b%b want 000002a3 flags 00", instr, rng, aln);
        end
        note_delivery(1'b0);
        send_one(32'h0000_0013, 32'd2048, IMM_I, instr, rng, aln, lat, ok);
        n_checks++; if (!ok || rng !== 1'b1 || aln !== 1'b0) begin n_fail++;
            $display("FAIL i_range_2048: got range=%b align=%b want 1 0", rng, aln); end
        n_checks++; if (instr !== model_pack(32'h13, 32'd2048, IMM_I)) begin n_fail++;
            $display("FAIL i_trunc_2048: got %h want %h", instr,
                     model_pack(32'h13, 32'd2048, IMM_I)); end
        note_delivery(model_range(32'd2048, IMM_I));
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
        n_checks++; if (err_count !== CntW'(ec_model) || ec_model != 1) begin n_fail++;
            $display("FAIL err_count_first: got %0d want 1", err_count); end
    endtask

    task automatic test_bj_format();
        logic [31:0] instr; logic rng, aln, ok; int lat;
        send_one(32'h0000_0063, 32'hFFFF_FFFE, IMM_B, instr, rng, aln, lat, ok);
        n_checks++; if (!ok || instr !== 32'hFE00_0FE3 || {rng, aln} !== 2'b00) begin n_fail++;
            $display("FAIL b_neg2: got %h flags %b%b want fe000fe3 flags 00", instr, rng, aln);
        end
        note_delivery(1'b0);
        send_one(32'h0000_0063, 32'd3, IMM_B, instr, rng, aln, lat, ok);
        n_checks++; if (!ok || aln !== 1'b1 || rng !== 1'b0) begin n_fail++;
            $display("FAIL b_align: got range=%b align=%b want 0 1", rng, aln); end
        n_checks++; if (instr !== model_pack(32'h63, 32'd3, IMM_B)) begin n_fail++;
            $display("FAIL b_align_instr: got %h want %h", instr,
                     model_pack(32'h63, 32'd3, IMM_B)); end
        note_delivery(model_align(32'd3, IMM_B));
        send_one(32'h0000_006F, 32'h0000_0800, IMM_J, instr, rng, aln, lat, ok);
        n_checks++; if (!ok || instr !== 32'h0010_006F || {rng, aln} !== 2'b00) begin n_fail++;
            $display("FAIL j_800: got %h flags %b%b want 0010006f flags 00", instr, rng, aln);
        end
        note_delivery(1'b0);
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
        n_checks++; if (err_count !== CntW'(ec_model)) begin n_fail++;
            $display("FAIL err_count_bj: got %0d want %0d", err_count, ec_model); end
    endtask

    task automatic test_backpressure();
        logic [31:0] bases[3], imms[3];
        logic [1:0]  srcs[3];
        logic [31:0] q_instr[$];
        logic        q_rng[$], q_aln[$];
        logic [31:0] hold, cb, ci;
        logic [1:0]  cs;
        logic        seen, stable, rng_e, aln_e;
        int          idx, got;
        bases = '{32'h0000_0013, 32'h0000_0023, 32'h0000_006F};
        imms  = '{32'd100, 32'hFFFF_FFF9, 32'h0000_1234};
        srcs  = '{IMM_I, IMM_S, IMM_J};
        idx = 0; seen = 1'b0; stable = 1'b1; hold = '0;
        for (int c = 0; c < 6; c++) begin
            cb = (idx < 3) ? bases[idx] : 32'h0;
            ci = (idx < 3) ? imms[idx]  : 32'h0;
            cs = (idx < 3) ? srcs[idx]  : 2'd0;
            drive(idx < 3, cb, ci, cs, 1'b0);
            if (bus.out_valid) begin
                if (!seen) begin hold = bus.out_instr; seen = 1'b1; end
                else if (bus.out_instr !== hold) stable = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_instr.push_back(model_pack(cb, ci, cs));
                q_rng.push_back(model_range(ci, cs));
                q_aln.push_back(model_align(ci, cs));
                idx++;
            end
        end
        n_checks++; if (idx != 2) begin n_fail++;
            $display("FAIL bp_accepted: got %0d beats want 2", idx); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (!seen || !stable || bus.out_instr !== q_instr[0]) begin n_fail++;
            $display("FAIL bp_stable: got %h seen=%b stable=%b want %h", bus.out_instr, seen,
                     stable, q_instr[0]); end
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            cb = (idx < 3) ? bases[idx] : 32'h0;
            ci = (idx < 3) ? imms[idx]  : 32'h0;
            cs = (idx < 3) ? srcs[idx]  : 2'd0;
            drive(idx < 3, cb, ci, cs, 1'b1);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (q_instr.size() == 0) begin n_fail++;
                    $display("FAIL bp_order: got extra beat %h want none", bus.out_instr);
                end else begin
                    rng_e = q_rng.pop_front(); aln_e = q_aln.pop_front();
                    if (bus.out_instr !== q_instr[0] || bus.out_range !== rng_e ||
                        bus.out_align !== aln_e) begin n_fail++;
                        $display("FAIL bp_order: got %h %b%b want %h %b%b", bus.out_instr,
                                 bus.out_range, bus.out_align, q_instr[0], rng_e, aln_e);
                    end
                    note_delivery(rng_e | aln_e);
                    void'(q_instr.pop_front());
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q_instr.push_back(model_pack(cb, ci, cs));
                q_rng.push_back(model_range(ci, cs));
                q_aln.push_back(model_align(ci, cs));
                idx++;
            end
        end
        n_checks++; if (got != 3 || q_instr.size() != 0) begin n_fail++;
            $display("FAIL bp_delivered: got %0d left %0d want 3 left 0", got, q_instr.size());
        end
    endtask

    task automatic test_round_trip();
        for (int f = 0; f < 4; f++) begin
            logic [31:0] q_instr[$], q_imm[$];
            logic        q_flag[$];
            logic [31:0] cb, ci, want_imm, want_instr;
            logic        flag_e;
            logic [1:0]  s;
            int          sent, dlv, cyc;
            s = 2'(f);
            sent = 0; dlv = 0; cyc = 0;
            cb = $urandom;
            ci = 32'($signed($urandom) >>> (31 - model_msb(s)));
            while (dlv < 1000 && cyc < 5000) begin
                drive(sent < 1000, cb, ci, s, $urandom_range(0, 3) != 0);
                cyc++;
                if (bus.out_valid && bus.out_ready) begin
                    n_checks++;
                    if (q_instr.size() == 0) begin n_fail++;
                        $display("FAIL rt_spurious fmt %0d: got %h want none", f, bus.out_instr);
                    end else begin
                        want_instr = q_instr.pop_front();
                        want_imm   = q_imm.pop_front();
                        flag_e     = q_flag.pop_front();
                        if (bus.out_instr !== want_instr) begin n_fail++;
                            $display("FAIL rt_instr fmt %0d: got %h want %h", f, bus.out_instr,
                                     want_instr); end
                        n_checks++;
                        if (extend(bus.out_instr, s) !== want_imm) begin n_fail++;
                            $display("FAIL rt_extend fmt %0d: got %h want %h", f,
                                     extend(bus.out_instr, s), want_imm); end
                        n_checks++;
                        if (bus.out_range !== 1'b0 || bus.out_align !== flag_e) begin n_fail++;
                            $display("FAIL rt_flags fmt %0d: got %b%b want 0%b", f,
                                     bus.out_range, bus.out_align, flag_e); end
                        note_delivery(flag_e);
                    end
                    dlv++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    q_instr.push_back(model_pack(cb, ci, s));
                    q_imm.push_back((s >= 2'd2) ? (ci & 32'hFFFF_FFFE) : ci);
                    q_flag.push_back(model_align(ci, s) | model_range(ci, s));
                    sent++;
                    cb = $urandom;
                    ci = 32'($signed($urandom) >>> (31 - model_msb(s)));
                end
            end
            n_checks++; if (dlv != 1000) begin n_fail++;
                $display("FAIL rt_count fmt %0d: got %0d want 1000", f, dlv); end
        end
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
        n_checks++; if (err_count !== CntW'(ec_model)) begin n_fail++;
            $display("FAIL rt_err_count: got %0d want %0d", err_count, ec_model); end
    endtask

    task automatic test_reset_mid_flight();
        int acc;
        logic stale;
        acc = 0;
        for (int c = 0; c < 6 && acc < 2; c++) begin
            drive(1'b1, 32'h13, 32'd4096, IMM_I, 1'b0);
            if (bus.in_valid && bus.in_ready) acc++;
        end
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        n_checks++; if (acc != 2 || bus.out_valid !== 1'b1) begin n_fail++;
            $display("FAIL rst_setup: got acc=%0d out_valid=%b want 2 1", acc, bus.out_valid);
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        ec_model = 0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_flush: got out_valid=%b in_ready=%b want 0 1", bus.out_valid,
                     bus.in_ready); end
        n_checks++; if (err_count !== '0) begin n_fail++;
            $display("FAIL rst_err_count: got %0d want 0", err_count); end
        rst = 1'b0;
        stale = 1'b0;
        repeat (10) begin
            drive(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++; if (stale) begin n_fail++;
            $display("FAIL rst_stale: got stale beat want none"); end
    endtask

    task automatic test_saturation();
        int sent;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            drive(sent < 20, 32'h63, 32'd1, IMM_B, 1'b1);
            n_checks++; if (err_count !== CntW'(ec_model)) begin n_fail++;
                $display("FAIL sat_count cycle %0d: got %0d want %0d", c, err_count, ec_model);
            end
            if (bus.out_valid && bus.out_ready) note_delivery(1'b1);
            if (bus.in_valid && bus.in_ready) sent++;
        end
        n_checks++; if (err_count !== CntW'(CntMax)) begin n_fail++;
            $display("FAIL sat_final: got %0d want %0d", err_count, CntMax); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_base   = '0;
        bus.in_imm    = '0;
        bus.in_src    = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_i_format();
        test_s_format();
        test_bj_format();
        test_backpressure();
        test_round_trip();
        test_reset_mid_flight();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
